prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot loader: default sizes and FSM state encoding.
package prog_loader_pkg;

  localparam int DefaultWordSize     = 16;
  localparam int DefaultProgAddrSize = 15;

  // Image header carries the word count as two bytes.
  localparam int LenBits = 16;

  typedef enum logic [2:0] {
    LdIdle   = 3'd0,
    LdLenHi  = 3'd1,
    LdLenLo  = 3'd2,
    LdDataHi = 3'd3,
    LdDataLo = 3'd4,
    LdCheck  = 3'd5,
    LdRun    = 3'd6,
    LdError  = 3'd7
  } ldState_t;

endpackage

// File: rtl/prog_loader.sv
// Boot sequencer: holds the cpu in reset, streams a program image into
// instruction ROM, verifies the XOR checksum, then releases the cpu.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WordSize     = DefaultWordSize,
  parameter int ProgAddrSize = DefaultProgAddrSize
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    rom_we,
  output logic [ProgAddrSize-1:0] rom_addr,
  output logic [WordSize-1:0]     rom_wdata,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  // Largest legal image; a full-size image ends exactly at address all-ones.
  localparam logic [31:0] MaxWords = 32'd1 << ProgAddrSize;

  ldState_t           state;
  logic [7:0]         lenHi;
  logic [7:0]         dataHi;
  logic [7:0]         checksum;
  logic [LenBits-1:0] wordTotal;
  logic [LenBits-1:0] wordCount;

  logic accept;
  assign accept = in_valid && in_ready;

  // Single FSM with all outputs registered; in_ready tracks the byte-receiving states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LdIdle;
      lenHi     <= '0;
      dataHi    <= '0;
      checksum  <= '0;
      wordTotal <= '0;
      wordCount <= '0;
      in_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        LdIdle, LdRun, LdError: begin
          if (start) begin
            state     <= LdLenHi;
            checksum  <= '0;
            wordCount <= '0;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        LdLenHi: begin
          if (accept) begin
            lenHi    <= in_data;
            checksum <= checksum ^ in_data;
            state    <= LdLenLo;
          end
        end
        LdLenLo: begin
          if (accept) begin
            wordTotal <= {lenHi, in_data};
            checksum  <= checksum ^ in_data;
            if ({16'd0, lenHi, in_data} > MaxWords) begin
              state    <= LdError;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else if ({lenHi, in_data} == '0) begin
              state <= LdCheck;
            end else begin
              state <= LdDataHi;
            end
          end
        end
        LdDataHi: begin
          if (accept) begin
            dataHi   <= in_data;
            checksum <= checksum ^ in_data;
            state    <= LdDataLo;
          end
        end
        LdDataLo: begin
          if (accept) begin
            rom_we    <= 1'b1;
            rom_addr  <= ProgAddrSize'(wordCount);
            rom_wdata <= WordSize'({dataHi, in_data});
            checksum  <= checksum ^ in_data;
            wordCount <= wordCount + 1'b1;
            // Counter never exceeds wordTotal, so the write address cannot wrap.
            if (wordCount + 1'b1 == wordTotal) begin
              state <= LdCheck;
            end else begin
              state <= LdDataHi;
            end
          end
        end
        LdCheck: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == checksum) begin
              state     <= LdRun;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= LdError;
              error <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
